// File: rtl/mdr_mem_ctrl.sv
// Memory data register with a built-in byte/half/word/full memory-access sequencer.
// It lane-extracts and extends read data, and replicates write data across the byte lanes.
//
// state   | meaning
// IDLE    | q loadable from bus, requests sampled
// RD_WAIT | mem_rd asserted, waiting for mem_ready or timeout
// WR_WAIT | mem_wr asserted, waiting for mem_ready or timeout
// FIN     | one-cycle done (plus error on failure)
module mdr_mem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT = '0,
    parameter int TIMEOUT = 15,
    parameter int OFF_W = $clog2(DATA_WIDTH/8)
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic                    enable,
    input  logic [DATA_WIDTH-1:0]   BusMuxOut,
    output logic [DATA_WIDTH-1:0]   BusMuxIn,
    input  logic                    rd_req,
    input  logic                    wr_req,
    input  logic [1:0]              size,
    input  logic                    sign_ext,
    input  logic [OFF_W-1:0]        byte_off,
    input  logic [DATA_WIDTH-1:0]   Mdatain,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);
    localparam int BW    = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, FIN} state_t;

    state_t                  state, state_nxt;
    logic                    err_q, err_nxt;
    logic [DATA_WIDTH-1:0]   q;
    logic [1:0]              size_q;
    logic                    sext_q;
    logic [OFF_W-1:0]        off_q;
    logic [BW-1:0]           be_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [CNT_W-1:0]        cnt;

    logic                    misalign, start_ok, timeout_hit;
    logic [BW-1:0]           mask;
    logic [DATA_WIDTH-1:0]   wdata_rep, rd_shift, rd_ext;

    assign start_ok    = (rd_req ^ wr_req) & ~misalign;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    assign rd_shift    = Mdatain >> {off_q, 3'b000};
    assign BusMuxIn    = q;

    always_comb begin
        misalign = 1'b0;
        mask     = '0;
        case (size)
            2'b00: begin misalign = 1'b0;               mask = BW'(1) << byte_off;    end
            2'b01: begin misalign = byte_off[0];        mask = BW'(3) << byte_off;    end
            2'b10: begin misalign = byte_off[1:0] != 2'b00; mask = BW'(15) << byte_off; end
            2'b11: begin misalign = byte_off != '0;     mask = '1;                    end
        endcase
    end

    // Sub-width writes repeat the low bytes of q so any lane the memory enables sees the data.
    always_comb begin
        wdata_rep = '0;
        for (int i = 0; i < BW; i++) begin
            case (size)
                2'b00: wdata_rep[i*8 +: 8] = q[7:0];
                2'b01: wdata_rep[i*8 +: 8] = q[(i % 2)*8 +: 8];
                2'b10: wdata_rep[i*8 +: 8] = q[(i % 4)*8 +: 8];
                2'b11: wdata_rep[i*8 +: 8] = q[i*8 +: 8];
            endcase
        end
    end

    always_comb begin
        rd_ext = Mdatain;
        case (size_q)
            2'b00: rd_ext = sext_q ? DATA_WIDTH'($signed(rd_shift[7:0]))  : DATA_WIDTH'(rd_shift[7:0]);
            2'b01: rd_ext = sext_q ? DATA_WIDTH'($signed(rd_shift[15:0])) : DATA_WIDTH'(rd_shift[15:0]);
            2'b10: rd_ext = sext_q ? DATA_WIDTH'($signed(rd_shift[31:0])) : DATA_WIDTH'(rd_shift[31:0]);
            2'b11: rd_ext = Mdatain;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        case (state)
            IDLE: begin
                if (rd_req | wr_req) begin
                    if ((rd_req & wr_req) | misalign) begin
                        state_nxt = FIN;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = rd_req ? RD_WAIT : WR_WAIT;
                        err_nxt   = 1'b0;
                    end
                end
            end
            RD_WAIT, WR_WAIT: begin
                // A ready arriving on the last allowed cycle still wins over the timeout.
                if (mem_ready) begin
                    state_nxt = FIN;
                    err_nxt   = 1'b0;
                end else if (timeout_hit) begin
                    state_nxt = FIN;
                    err_nxt   = 1'b1;
                end
            end
            FIN: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_rd    = (state == RD_WAIT);
        mem_wr    = (state == WR_WAIT);
        mem_be    = (mem_rd | mem_wr) ? be_q : '0;
        mem_wdata = wdata_q;
        busy      = (state != IDLE);
        done      = (state == FIN);
        error     = (state == FIN) & err_q;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            q       <= INIT;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            off_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start_ok) begin
                        size_q <= size;
                        sext_q <= sign_ext;
                        off_q  <= byte_off;
                        be_q   <= mask;
                        if (wr_req)
                            wdata_q <= wdata_rep;
                    end else if (!(rd_req | wr_req) && enable) begin
                        q <= BusMuxOut;
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mem_ready)
                        q <= rd_ext;
                end
                WR_WAIT: cnt <= cnt + CNT_W'(1);
                FIN:     cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// Directed self-checking bench for mdr_mem_ctrl: bus load, reads, writes, errors, timeout, reset.
module tb_mdr_mem_ctrl;
    logic        clock, clear, enable, rd_req, wr_req, sign_ext, mem_ready;
    logic [31:0] BusMuxOut, BusMuxIn, Mdatain, mem_wdata;
    logic [1:0]  size, byte_off;
    logic        mem_rd, mem_wr, busy, done, error;
    logic [3:0]  mem_be;
    int          checks, errors;

    mdr_mem_ctrl dut (
        .clock(clock), .clear(clear), .enable(enable), .BusMuxOut(BusMuxOut),
        .BusMuxIn(BusMuxIn), .rd_req(rd_req), .wr_req(wr_req), .size(size),
        .sign_ext(sign_ext), .byte_off(byte_off), .Mdatain(Mdatain),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .busy(busy), .done(done), .error(error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1; enable = 0; rd_req = 0; wr_req = 0; size = 0; sign_ext = 0;
        byte_off = 0; mem_ready = 0; BusMuxOut = 0; Mdatain = 0;
        step(); step();
        checks++;
        if (BusMuxIn !== 32'h0) begin errors++; $display("FAIL reset_q got %h exp %h", BusMuxIn, 32'h0); end
        checks++;
        if ({mem_rd, mem_wr, busy, done, error} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 00000", {mem_rd, mem_wr, busy, done, error});
        end
        checks++;
        if (mem_be !== 4'h0 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_mem got be=%h wd=%h exp 0/0", mem_be, mem_wdata);
        end
        clear = 1'b0;
        step();
    endtask

    task automatic test_bus_load();
        enable = 1; BusMuxOut = 32'hDEADBEEF;
        step();
        enable = 0;
        checks++;
        if (BusMuxIn !== 32'hDEADBEEF) begin errors++; $display("FAIL bus_load got %h exp DEADBEEF", BusMuxIn); end
        checks++;
        if ({mem_rd, mem_wr, busy} !== 3'b000) begin errors++; $display("FAIL bus_load_strobe got %b exp 000", {mem_rd, mem_wr, busy}); end
    endtask

    task automatic test_signed_byte_read();
        rd_req = 1; size = 2'b00; byte_off = 2; sign_ext = 1; Mdatain = 32'h1280_5634; mem_ready = 0;
        step();
        rd_req = 0; sign_ext = 0; byte_off = 0;
        enable = 1; BusMuxOut = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_rd !== 1'b1 || mem_be !== 4'b0100 || busy !== 1'b1 || done !== 1'b0) begin
                errors++; $display("FAIL sbyte_wait%0d got rd=%b be=%b busy=%b done=%b exp 1/0100/1/0", i, mem_rd, mem_be, busy, done);
            end
            step();
        end
        checks++;
        if (BusMuxIn !== 32'hDEADBEEF) begin errors++; $display("FAIL sbyte_enable_busy got %h exp DEADBEEF", BusMuxIn); end
        mem_ready = 1;
        step();
        mem_ready = 0;
        checks++;
        if (BusMuxIn !== 32'hFFFF_FF80) begin errors++; $display("FAIL sbyte_q got %h exp FFFFFF80", BusMuxIn); end
        checks++;
        if ({done, error, mem_rd, mem_be} !== {3'b100, 4'h0}) begin
            errors++; $display("FAIL sbyte_fin got done=%b err=%b rd=%b be=%b exp 1/0/0/0000", done, error, mem_rd, mem_be);
        end
        step();
        enable = 0;
        checks++;
        if ({done, busy} !== 2'b00) begin errors++; $display("FAIL sbyte_after got done=%b busy=%b exp 0/0", done, busy); end
    endtask

    task automatic test_zero_wait_read();
        rd_req = 1; size = 2'b01; byte_off = 2; sign_ext = 0; Mdatain = 32'h8001_7F00; mem_ready = 1;
        step();
        rd_req = 0;
        checks++;
        if (BusMuxIn !== 32'hFFFF_FF80 || done !== 1'b0) begin
            errors++; $display("FAIL zw_early got q=%h done=%b exp FFFFFF80/0", BusMuxIn, done);
        end
        step();
        mem_ready = 0;
        checks++;
        if (BusMuxIn !== 32'h0000_8001 || done !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL zw_half_read got q=%h done=%b err=%b exp 00008001/1/0", BusMuxIn, done, error);
        end
        step();
    endtask

    task automatic test_half_write();
        enable = 1; BusMuxOut = 32'h0000_A5C3;
        step();
        enable = 0;
        wr_req = 1; size = 2'b01; byte_off = 2; mem_ready = 1;
        step();
        wr_req = 0;
        checks++;
        if (mem_wr !== 1'b1 || mem_be !== 4'b1100 || mem_wdata !== 32'hA5C3_A5C3) begin
            errors++; $display("FAIL hwrite got wr=%b be=%b wd=%h exp 1/1100/A5C3A5C3", mem_wr, mem_be, mem_wdata);
        end
        step();
        mem_ready = 0;
        checks++;
        if (mem_wr !== 1'b0 || done !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL hwrite_fin got wr=%b done=%b err=%b exp 0/1/0", mem_wr, done, error);
        end
        step();
    endtask

    task automatic test_byte_write_wait();
        wr_req = 1; size = 2'b00; byte_off = 1; mem_ready = 0;
        step();
        wr_req = 0;
        step();
        checks++;
        if (mem_wr !== 1'b1 || mem_be !== 4'b0010 || mem_wdata !== 32'hC3C3_C3C3) begin
            errors++; $display("FAIL bwrite got wr=%b be=%b wd=%h exp 1/0010/C3C3C3C3", mem_wr, mem_be, mem_wdata);
        end
        mem_ready = 1;
        step();
        mem_ready = 0;
        checks++;
        if (done !== 1'b1 || mem_wr !== 1'b0) begin errors++; $display("FAIL bwrite_fin got done=%b wr=%b exp 1/0", done, mem_wr); end
        step();
    endtask

    task automatic test_errors();
        rd_req = 1; size = 2'b10; byte_off = 1; Mdatain = 32'h5555_5555; mem_ready = 1;
        step();
        rd_req = 0;
        checks++;
        if ({done, error, mem_rd, mem_be} !== {3'b110, 4'h0}) begin
            errors++; $display("FAIL misalign got done=%b err=%b rd=%b be=%b exp 1/1/0/0000", done, error, mem_rd, mem_be);
        end
        step();
        checks++;
        if ({done, error, busy} !== 3'b000) begin errors++; $display("FAIL misalign_after got %b exp 000", {done, error, busy}); end
        rd_req = 1; wr_req = 1; size = 2'b00; byte_off = 0;
        step();
        rd_req = 0; wr_req = 0; mem_ready = 0;
        checks++;
        if ({done, error, mem_rd, mem_wr} !== 4'b1100) begin
            errors++; $display("FAIL conflict got done=%b err=%b rd=%b wr=%b exp 1/1/0/0", done, error, mem_rd, mem_wr);
        end
        step();
        checks++;
        if (BusMuxIn !== 32'h0000_A5C3) begin errors++; $display("FAIL error_q got %h exp 0000A5C3", BusMuxIn); end
    endtask

    task automatic test_timeout();
        int n;
        rd_req = 1; size = 2'b10; byte_off = 0; Mdatain = 32'h1234_5678; mem_ready = 0;
        step();
        rd_req = 0;
        n = 0;
        while (mem_rd === 1'b1 && n < 40) begin
            n++;
            step();
        end
        checks++;
        if (n !== 15) begin errors++; $display("FAIL timeout_len got %0d exp 15", n); end
        checks++;
        if (done !== 1'b1 || error !== 1'b1 || BusMuxIn !== 32'h0000_A5C3) begin
            errors++; $display("FAIL timeout_fin got done=%b err=%b q=%h exp 1/1/0000A5C3", done, error, BusMuxIn);
        end
        step();
        rd_req = 1;
        step();
        rd_req = 0;
        for (int i = 0; i < 14; i++) step();
        checks++;
        if (mem_rd !== 1'b1) begin errors++; $display("FAIL late_ready_rd got %b exp 1", mem_rd); end
        mem_ready = 1;
        step();
        mem_ready = 0;
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || BusMuxIn !== 32'h1234_5678) begin
            errors++; $display("FAIL late_ready got done=%b err=%b q=%h exp 1/0/12345678", done, error, BusMuxIn);
        end
        step();
    endtask

    task automatic test_reset_mid_access();
        wr_req = 1; size = 2'b11; byte_off = 0; mem_ready = 0;
        step();
        wr_req = 0;
        checks++;
        if (mem_wr !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got wr=%b exp 1", mem_wr); end
        #2 clear = 1;
        #1;
        checks++;
        if (mem_wr !== 1'b0 || busy !== 1'b0 || BusMuxIn !== 32'h0) begin
            errors++; $display("FAIL rst_mid_async got wr=%b busy=%b q=%h exp 0/0/00000000", mem_wr, busy, BusMuxIn);
        end
        step();
        clear = 0;
        step();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b exp 0", done); end
        rd_req = 1; size = 2'b00; byte_off = 3; sign_ext = 0; Mdatain = 32'hAB00_0000; mem_ready = 1;
        step();
        rd_req = 0;
        step();
        mem_ready = 0;
        checks++;
        if (BusMuxIn !== 32'h0000_00AB || done !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL rst_mid_next got q=%h done=%b err=%b exp 000000AB/1/0", BusMuxIn, done, error);
        end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_bus_load();
        test_signed_byte_read();
        test_zero_wait_read();
        test_half_write();
        test_byte_write_wait();
        test_errors();
        test_timeout();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdr_mem_ctrl.md
Name: mdr_mem_ctrl

Overview:
Parametrised memory data register with a built-in memory-access sequencer for the datapath. It holds one data word that can be loaded from the CPU bus or from memory. It runs byte, halfword, word and full-width reads and writes with a ready/wait-state handshake. Read data is lane-extracted and sign- or zero-extended; write data is lane-replicated with byte enables. It sits between the internal bus (BusMuxOut/BusMuxIn) and the memory subsystem, driven by the control unit.

Parameters:
DATA_WIDTH, 32, register and memory data width; multiple of 8, at least 32.
INIT, 0, register value after clear.
TIMEOUT, 15, maximum cycles waiting for mem_ready before aborting; must be at least 1.
OFF_W, $clog2(DATA_WIDTH/8), byte-offset width (derived, not overridden).

Ports:
clock  in  1  rising-edge clock
clear  in  1  asynchronous active-high reset
enable  in  1  load q from BusMuxOut (honoured only in IDLE)
BusMuxOut  in  DATA_WIDTH  CPU bus data in
BusMuxIn  out  DATA_WIDTH  register contents to bus (q)
rd_req  in  1  start memory read (sampled in IDLE)
wr_req  in  1  start memory write (sampled in IDLE)
size  in  2  00 byte, 01 half, 10 word (32b), 11 full DATA_WIDTH
sign_ext  in  1  1 = sign-extend sub-width reads, 0 = zero-extend
byte_off  in  OFF_W  low address bits selecting byte lane
Mdatain  in  DATA_WIDTH  memory read data, valid when mem_ready
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_be  out  DATA_WIDTH/8  byte enables
mem_wdata  out  DATA_WIDTH  write data
mem_ready  in  1  memory completes the access this cycle
busy  out  1  access in progress
done  out  1  one-cycle completion pulse
error  out  1  one-cycle pulse, same cycle as done, on a failed access

Behaviour:
- Reset (clear=1, async): q=INIT; state=IDLE; mem_rd, mem_wr, busy, done, error=0; mem_be=0; mem_wdata=0; timeout counter=0. Reset asserted mid-access aborts the access immediately, with no done pulse.
- States: IDLE, RD_WAIT, WR_WAIT, FIN.
- IDLE:
  - rd_req and wr_req both 1 -> FIN with error=1; no memory strobe.
  - Misaligned request (half with byte_off[0]=1; word with byte_off[1:0]!=0; full with byte_off!=0) -> FIN with error=1.
  - Valid rd_req -> RD_WAIT. Latch size, sign_ext, byte_off. Assert mem_rd, mem_be = lane mask.
  - Valid wr_req -> WR_WAIT. Assert mem_wr, mem_be, mem_wdata.
  - Otherwise, if enable=1: q <= BusMuxOut.
  - Requests take priority over enable in the same cycle.
- Lane mask: byte 1<<off; half 2'b11<<off; word 4'hF<<off; full all ones.
- mem_wdata: q[7:0] replicated across all lanes (byte), q[15:0] replicated (half), q[31:0] replicated (word), q (full).
- RD_WAIT / WR_WAIT:
  - Strobe, mem_be and mem_wdata stay stable until mem_ready.
  - mem_ready=1: strobe drops next cycle; go to FIN. A read loads q with the selected lane, extended to DATA_WIDTH per the latched sign_ext.
  - Timeout counter increments each waiting cycle. Reaching TIMEOUT without mem_ready -> FIN with error=1; q unchanged.
  - mem_ready in the same cycle the counter hits TIMEOUT counts as success.
- FIN: done=1 for one cycle (error=1 too if failed); mem_be=0; -> IDLE. Requests and enable are ignored in FIN.
- Latency: a zero-wait-state read (mem_ready high in the first RD_WAIT cycle) updates q and pulses done 2 cycles after the rd_req edge.
- busy=1 in RD_WAIT, WR_WAIT and FIN.
- enable, rd_req and wr_req are ignored while busy.
- BusMuxIn = q combinationally at all times.

Test Plan:
- Bus load: clear, then enable=1, BusMuxOut=32'hDEADBEEF -> BusMuxIn=32'hDEADBEEF the next cycle; rd_req=0 so no strobe.
- Signed byte read: rd_req, size=00, byte_off=2, sign_ext=1, Mdatain=32'h1280_5634, mem_ready after 3 wait cycles -> mem_be=4'b0100, q=32'hFFFF_FF80, done one cycle, error=0.
- Halfword write: q=32'h0000_A5C3, wr_req, size=01, byte_off=2, mem_ready immediate -> mem_be=4'b1100, mem_wdata=32'hA5C3_A5C3, mem_wr high exactly 1 cycle.
- Misaligned/conflict: word read with byte_off=1 -> error+done pulse, no mem_rd. rd_req and wr_req together -> same result, q unchanged.
- Timeout: read with mem_ready held 0, TIMEOUT=15 -> mem_rd high 15 cycles, then error+done, q retains old value. Repeat with mem_ready on cycle 15 -> success.
- Reset mid-access: assert clear during WR_WAIT -> mem_wr=0 immediately (async), q=INIT, no done; the next request proceeds normally.
